// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default bus widths, the stage
// occupancy encoding, and field offsets for packing the ctrl/data buses.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 128;

    // Occupancy state; the encoding equals the number of valid entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // ID/EX control bus bit positions.
    localparam int unsigned ID_EX_JR       = 0;
    localparam int unsigned ID_EX_BRANCH   = 1;
    localparam int unsigned ID_EX_JUMP     = 2;
    localparam int unsigned ID_EX_REG_IMM  = 3;
    localparam int unsigned ID_EX_EXT_SH   = 4;
    localparam int unsigned ID_EX_EXT_LH   = 5;
    localparam int unsigned ID_EX_JAL      = 6;
    localparam int unsigned ID_EX_MEMWRITE = 7;
    localparam int unsigned ID_EX_REGWRITE = 8;
    localparam int unsigned ID_EX_MEMTOREG = 9;

    // ID/EX data bus field offsets (LSB) and widths.
    localparam int unsigned ID_EX_RD_LSB   = 0;
    localparam int unsigned ID_EX_RD_W     = 5;
    localparam int unsigned ID_EX_RT_LSB   = 5;
    localparam int unsigned ID_EX_RT_W     = 5;
    localparam int unsigned ID_EX_RS_LSB   = 10;
    localparam int unsigned ID_EX_RS_W     = 5;
    localparam int unsigned ID_EX_IMM_LSB  = 16;
    localparam int unsigned ID_EX_IMM_W    = 32;
    localparam int unsigned ID_EX_OPB_LSB  = 48;
    localparam int unsigned ID_EX_OPB_W    = 32;
    localparam int unsigned ID_EX_OPA_LSB  = 80;
    localparam int unsigned ID_EX_OPA_W    = 32;
    localparam int unsigned ID_EX_PC_LSB   = 112;
    localparam int unsigned ID_EX_PC_W     = 16;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + ctrl + data register, updated on the falling edge.
//   clk, rst_n   : falling-edge clock, async active-low reset
//   i_load       : capture i_ctrl/i_data and set valid (wins over i_clear)
//   i_clear      : drop valid and zero ctrl; data zeroed only if FLUSH_DATA
//   o_valid/o_ctrl/o_data : held entry contents
module pipe_entry #(
    parameter int unsigned CTRL_W     = 10,
    parameter int unsigned DATA_W     = 128,
    parameter bit          FLUSH_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Ctrl is zeroed on every clear so an invalid entry always reads as a no-op.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (FLUSH_DATA) begin
                r_data <= '0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer (MAIN drives outputs, SKID absorbs one beat of backpressure).
// All state updates on the falling edge of clk; rst is async active-low.
//   flush                       : squash held and incoming beats (ctrl zeroed)
//   in_valid/in_ready/in_ctrl/in_data      : upstream handshake and payload
//   out_valid/out_ready/out_ctrl/out_data  : downstream handshake and payload
//   occupancy                   : number of valid entries (0..2)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          FLUSH_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_state_t        r_state;
    occ_state_t        w_state_nxt;
    logic              r_in_ready;

    logic              w_push;
    logic              w_pop;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = w_main_valid & out_ready;

    // Occupancy state register; in_ready is registered from the next state
    // so it never depends combinationally on out_ready.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state and entry control; flush overrides push and pop.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_push) begin
                        w_main_load = 1'b1;
                    end else if (w_pop) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end else if (w_push) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // SKID holds the younger beat; it moves up on pop.
                    if (w_pop) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .FLUSH_DATA (FLUSH_DATA)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .FLUSH_DATA (FLUSH_DATA)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // MAIN ctrl is zeroed whenever its valid drops, so it can drive out_ctrl directly.
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;
    assign in_ready  = r_in_ready;
    assign occupancy = 2'(r_state);

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed control bus and one packed data bus between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure from the downstream stage no longer needs a combinational stall path upstream.
- Flush inserts a bubble whose control fields are zero, i.e. a no-op: no RegWrite, no MemWrite, no branch or jump.

Parameters:
- CTRL_W, 10: width of packed control bus (WB/M/EX control bits).
- DATA_W, 128: width of packed data bus (PC, operands, immediate, register ids).
- FLUSH_DATA, 0: 1 = zero data fields on flush/bubble; 0 = leave data fields unchanged (ctrl is always zeroed).

Ports:
- clk, in, 1: clock; all state updates on the falling edge, matching the existing pipeline registers.
- rst, in, 1: asynchronous reset, active-low.
- flush, in, 1: synchronous squash of all held and incoming entries.
- in_valid, in, 1: upstream beat valid.
- in_ready, out, 1: stage can accept a beat.
- in_ctrl, in, CTRL_W: upstream control.
- in_data, in, DATA_W: upstream data.
- out_valid, out, 1: downstream beat valid.
- out_ready, in, 1: downstream accepts beat.
- out_ctrl, out, CTRL_W: control to next stage; all-zero whenever out_valid=0.
- out_data, out, DATA_W: data to next stage.
- occupancy, out, 2: number of valid entries (0..2).

Behaviour:
- Two entries: MAIN (drives outputs) and SKID (overflow). Each entry holds valid, ctrl and data. No combinational path from in_* to out_*.
- Reset (rst=0, asynchronous): both valids=0, all ctrl/data=0. Outputs during reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Handshake definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~SKID.valid, a registered value only; it never depends on out_ready.
- out_valid = MAIN.valid. out_ctrl = MAIN.valid ? MAIN.ctrl : 0.
- Latency: a beat pushed at edge N is visible on out_* after edge N. Sustained throughput is 1 beat/cycle while out_ready=1.
- State transitions at each falling edge, when flush=0:
  - Empty (occ 0): push -> MAIN=in; occ 1.
  - One (occ 1), pop & push -> MAIN=in; occ 1.
  - One, pop & ~push -> MAIN.valid=0; occ 0.
  - One, ~pop & push -> SKID=in; occ 2; in_ready falls.
  - One, ~pop & ~push -> hold.
  - Full (occ 2), pop -> MAIN=SKID, SKID.valid=0; occ 1; in_ready rises. No push is possible here because in_ready=0.
  - Full, ~pop -> hold all state.
- Order is preserved: SKID always holds the younger beat.
- Flush (flush=1 at edge): takes priority over push and pop.
  - Both valids cleared and both ctrl fields zeroed.
  - Data zeroed only if FLUSH_DATA=1.
  - A beat offered on in_* in the same cycle is discarded; upstream sees it as accepted only if in_ready was 1.
  - After the edge: occ 0, in_ready=1.
- Held entries are stable: while ~pop, out_ctrl and out_data must not change.
- rst asserted mid-transfer: all state is cleared immediately, without waiting for a clock edge; the in-flight beat is lost.
- Simultaneous flush and rst: reset wins.
- Widths are passed through unmodified; there is no arithmetic.

Decomposition:
- Shared package pipe_pkg holds:
  - Default width constants (CTRL_W, DATA_W).
  - Per-stage field offset constants used to pack and unpack ctrl/data buses (e.g. ID_EX ctrl layout: MemtoReg, RegWrite, MemWrite, Jal, ExtendLH, ExtendSH, Reg_imm, Jump, Branch, Jr).
- One natural sub-module: pipe_entry, a single valid+ctrl+data register with load/clear/zero-ctrl controls, instantiated twice (MAIN, SKID).

Test Plan:
- Reset then single beat: rst low 2 cycles, then in_valid=1, in_ctrl=10'h2A5, in_data=128'h1234 with out_ready=1 -> after next edge out_valid=1, out_ctrl=2A5, out_data=1234, occupancy=1; beat drains the following edge.
- Backpressure fill: out_ready=0, push beats A then B -> occupancy=2, in_ready=0, out shows A. Release out_ready -> A, then B, in order; in_ready=1 after first pop.
- Streaming: 20 consecutive beats with incrementing data, out_ready=1 -> 20 outputs, one per cycle, in order, no gaps after the first.
- Flush at full: occupancy=2, assert flush with in_valid=0 -> after edge out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; with FLUSH_DATA=0, out_data still equals A's data.
- Flush with concurrent push: occupancy=1, flush=1, in_valid=1, data C -> C never appears on output; occupancy=0.
- Async reset mid-stream: drop rst between edges while occupancy=2 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 immediately, without waiting for an edge.
